// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encodings and parameter defaults.
// Optional macro PWM_GLITCH_FILTER_EN adds the glitch-filter length default.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam int COUNT_BITS_DEF = 10;

`ifdef PWM_GLITCH_FILTER_EN
  localparam int FILTER_LEN_DEF = 3;
`endif

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Input path for pwm_capture: 2-FF synchronizer, optional glitch filter, edge detector.
// Macro PWM_GLITCH_FILTER_EN inserts a FILTER_LEN stable-sample filter before edge detection.
module pwm_capture_sync_edge
`ifdef PWM_GLITCH_FILTER_EN
  import pwm_capture_pkg::*;
  #(
    parameter int FILTER_LEN = FILTER_LEN_DEF
  )
`endif
  (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
  );

  logic sync1;
  logic sync2;
  logic s_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] LAST = FW'(FILTER_LEN - 1);

  logic [FW-1:0] stable_cnt;
  logic          filt;

  // The filtered level only follows sync2 once it has disagreed for FILTER_LEN samples in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt       <= 1'b0;
      stable_cnt <= '0;
    end else if (sync2 != filt) begin
      if (stable_cnt == LAST) begin
        filt       <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  assign s = filt;
`else
  assign s = sync2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of pwm_in in clk cycles, one result per period.
// Optional macro PWM_GLITCH_FILTER_EN enables the input glitch filter (FILTER_LEN samples).
module pwm_capture
  import pwm_capture_pkg::*;
  #(
    parameter int COUNT_BITS = COUNT_BITS_DEF
`ifdef PWM_GLITCH_FILTER_EN
    , parameter int FILTER_LEN = FILTER_LEN_DEF
`endif
  )
  (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_in,
    output logic [COUNT_BITS-1:0] high_cnt,
    output logic [COUNT_BITS-1:0] period_cnt,
    output logic                  rdy,
    output logic                  no_sig,
    output logic                  level
  );

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [COUNT_BITS-1:0] CNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  state_t                state;
  logic [COUNT_BITS-1:0] cnt;
  logic [COUNT_BITS-1:0] high_tmp;
  logic                  s;
  logic                  rise;
  logic                  fall;

  pwm_capture_sync_edge
`ifdef PWM_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
    );

  assign level = s;

  // Timeout fires at CNT_MAX, so cnt saturates there instead of wrapping; an edge always beats the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WAIT_RISE;
      cnt        <= '0;
      high_tmp   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      rdy        <= 1'b0;
      no_sig     <= 1'b1;
    end else begin
      rdy <= 1'b0;
      case (state)
        WAIT_RISE: begin
          if (rise) begin
            state <= MEAS_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        MEAS_HIGH: begin
          if (rise) begin
            cnt <= CNT_ONE;
          end else if (fall) begin
            high_tmp <= cnt;
            state    <= MEAS_LOW;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end else if (cnt == CNT_MAX) begin
            state  <= WAIT_RISE;
            no_sig <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            high_cnt   <= high_tmp;
            period_cnt <= cnt;
            rdy        <= 1'b1;
            no_sig     <= 1'b0;
            cnt        <= CNT_ONE;
            state      <= MEAS_HIGH;
          end else if (cnt == CNT_MAX) begin
            state  <= WAIT_RISE;
            no_sig <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= WAIT_RISE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
